// File: rtl/snake_game_ctrl.sv
// Game-flow controller for the 8x8 snake core: sequences idle/play/pause/over,
// generates the score-dependent move schedule, the one-second tick, the
// session high score and a display blink phase. All outputs are registered.
module snake_game_ctrl #(
    parameter int BASE_PERIOD  = 25_000_000,
    parameter int PERIOD_STEP  = 2_500_000,
    parameter int MIN_PERIOD   = 6_250_000,
    parameter int LEVEL_SCORE  = 5,
    parameter int ONE_SEC      = 50_000_000,
    parameter int OVER_HOLD    = 100_000_000,
    parameter int BLINK_PERIOD = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_val,
    input  logic       key_pressed,
    input  logic       core_game_over,
    input  logic [6:0] core_score,
    output logic       core_rst_n,
    output logic       core_key_pressed,
    output logic [3:0] core_key_val,
    output logic       step_en,
    output logic       sec_en,
    output logic [1:0] state,
    output logic [6:0] high_score,
    output logic       blink
);

    localparam logic [3:0] KEY_SP = 4'h5;
    localparam logic [3:0] KEY_AB = 4'hA;

    // Divisors guarded so degenerate parameter sets still elaborate.
    localparam int LVL_DIV  = (LEVEL_SCORE < 1) ? 1 : LEVEL_SCORE;
    localparam int STEP_DIV = (PERIOD_STEP < 1) ? 1 : PERIOD_STEP;
    localparam int MAX_LVL  = (BASE_PERIOD > MIN_PERIOD) ? (BASE_PERIOD - MIN_PERIOD) / STEP_DIV : 0;
    localparam int PMAX     = (BASE_PERIOD > MIN_PERIOD) ? BASE_PERIOD : MIN_PERIOD;

    localparam int SW = $clog2(PMAX + 1);
    localparam int CW = $clog2(ONE_SEC + 1);
    localparam int HW = $clog2(OVER_HOLD + 1);
    localparam int BW = $clog2(BLINK_PERIOD + 1);

    localparam logic [CW-1:0] SEC_LAST   = CW'(ONE_SEC - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(OVER_HOLD - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t         st, nst;
    logic [SW-1:0]  step_cnt, step_nxt, step_last;
    logic [CW-1:0]  sec_cnt, sec_nxt;
    logic [HW-1:0]  hold_cnt, hold_nxt;
    logic [BW-1:0]  blink_cnt;
    logic           key_sp, key_ab, key_dir, fwd;
    logic           blink_on, blink_was_on;
    int             lvl_i, per_i;

    assign state = st;

    // Key decode and next-state selection; game over outranks any key in PLAY.
    always_comb begin
        key_sp  = key_pressed && (key_val == KEY_SP);
        key_ab  = key_pressed && (key_val == KEY_AB);
        key_dir = key_pressed && (key_val inside {4'h2, 4'h4, 4'h6, 4'h8});
        fwd     = (st == S_PLAY) && !core_game_over && key_dir;
        nst     = st;
        case (st)
            S_IDLE:  if (key_sp) nst = S_PLAY;
            S_PLAY: begin
                if (core_game_over)  nst = S_OVER;
                else if (key_sp)     nst = S_PAUSE;
                else if (key_ab)     nst = S_IDLE;
            end
            S_PAUSE: begin
                if (key_sp)          nst = S_PLAY;
                else if (key_ab)     nst = S_IDLE;
            end
            S_OVER:  if (key_sp && hold_cnt == HOLD_LAST) nst = S_IDLE;
            default: nst = S_IDLE;
        endcase
    end

    // Move period from the current score: one level per LEVEL_SCORE points, floored.
    always_comb begin
        lvl_i = int'(core_score) / LVL_DIV;
        if (lvl_i > MAX_LVL) lvl_i = MAX_LVL;
        per_i = BASE_PERIOD - lvl_i * PERIOD_STEP;
        if (per_i < MIN_PERIOD) per_i = MIN_PERIOD;
        if (per_i < 1) per_i = 1;
        step_last = SW'(per_i - 1);
    end

    // Counter advance. A counter wraps in the cycle its pulse is high; it only
    // advances on edges that stay in PLAY, so pause freezes it at the count shown.
    always_comb begin
        if (nst == S_IDLE)                   step_nxt = '0;
        else if (st == S_PLAY && step_en)    step_nxt = '0;
        else if (st == S_PLAY && nst == S_PLAY) step_nxt = step_cnt + SW'(1);
        else                                 step_nxt = step_cnt;

        if (nst == S_IDLE)                   sec_nxt = '0;
        else if (st == S_PLAY && sec_en)     sec_nxt = '0;
        else if (st == S_PLAY && nst == S_PLAY) sec_nxt = sec_cnt + CW'(1);
        else                                 sec_nxt = sec_cnt;

        if (nst != S_OVER || st != S_OVER)   hold_nxt = '0;
        else if (hold_cnt != HOLD_LAST)      hold_nxt = hold_cnt + HW'(1);
        else                                 hold_nxt = hold_cnt;

        blink_on     = (nst == S_PAUSE) || (nst == S_OVER);
        blink_was_on = (st == S_PAUSE) || (st == S_OVER);
    end

    // State, counters and all registered outputs, precomputed from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st               <= S_IDLE;
            core_rst_n       <= 1'b0;
            core_key_pressed <= 1'b0;
            core_key_val     <= '0;
            step_en          <= 1'b0;
            sec_en           <= 1'b0;
            high_score       <= '0;
            blink            <= 1'b0;
            step_cnt         <= '0;
            sec_cnt          <= '0;
            hold_cnt         <= '0;
            blink_cnt        <= '0;
        end else begin
            st               <= nst;
            core_rst_n       <= (nst != S_IDLE);
            core_key_pressed <= fwd;
            core_key_val     <= fwd ? key_val : 4'h0;
            step_cnt         <= step_nxt;
            sec_cnt          <= sec_nxt;
            hold_cnt         <= hold_nxt;
            step_en          <= (nst == S_PLAY) && (step_nxt >= step_last);
            sec_en           <= (nst == S_PLAY) && (sec_nxt == SEC_LAST);

            if (st == S_PLAY && core_game_over && core_score > high_score)
                high_score <= core_score;

            if (!blink_on) begin
                blink_cnt <= '0;
                blink     <= 1'b0;
            end else if (!blink_was_on) begin
                blink_cnt <= '0;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with small simulation parameters.
module tb_snake_game_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_val = 4'h0;
    logic       key_pressed = 1'b0;
    logic       core_game_over = 1'b0;
    logic [6:0] core_score = 7'd0;
    logic       core_rst_n, core_key_pressed, step_en, sec_en, blink;
    logic [3:0] core_key_val;
    logic [1:0] state;
    logic [6:0] high_score;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    snake_game_ctrl #(
        .BASE_PERIOD(20), .PERIOD_STEP(4), .MIN_PERIOD(8), .LEVEL_SCORE(5),
        .ONE_SEC(50), .OVER_HOLD(30), .BLINK_PERIOD(10)
    ) dut (
        .clk(clk), .rst(rst), .key_val(key_val), .key_pressed(key_pressed),
        .core_game_over(core_game_over), .core_score(core_score),
        .core_rst_n(core_rst_n), .core_key_pressed(core_key_pressed),
        .core_key_val(core_key_val), .step_en(step_en), .sec_en(sec_en),
        .state(state), .high_score(high_score), .blink(blink)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       kp;
        logic [3:0] kv;
        logic [1:0] e_state;
        logic       e_rstn;
        logic       e_ckp;
        logic [3:0] e_ckv;
    } vec_t;

    vec_t vt[16];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_step(output int t);
        t = -1;
        for (int i = 0; i < 100 && t < 0; i++) begin
            tick();
            if (step_en) t = cyc;
        end
    endtask

    task automatic press(input logic [3:0] k);
        key_pressed = 1'b1;
        key_val = k;
        tick();
        key_pressed = 1'b0;
        key_val = 4'h0;
    endtask

    int step_q[$];
    int sec_q[$];
    int t0, t1, t2, s, m, ps, r, g, first, bad, bbad;

    initial begin
        vt[0]  = '{1'b1, 4'h6, 2'd0, 1'b0, 1'b0, 4'h0};
        vt[1]  = '{1'b1, 4'hA, 2'd0, 1'b0, 1'b0, 4'h0};
        vt[2]  = '{1'b1, 4'h5, 2'd1, 1'b1, 1'b0, 4'h0};
        vt[3]  = '{1'b1, 4'h8, 2'd1, 1'b1, 1'b1, 4'h8};
        vt[4]  = '{1'b0, 4'h0, 2'd1, 1'b1, 1'b0, 4'h0};
        vt[5]  = '{1'b1, 4'h7, 2'd1, 1'b1, 1'b0, 4'h0};
        vt[6]  = '{1'b1, 4'h4, 2'd1, 1'b1, 1'b1, 4'h4};
        vt[7]  = '{1'b1, 4'h5, 2'd2, 1'b1, 1'b0, 4'h0};
        vt[8]  = '{1'b1, 4'h6, 2'd2, 1'b1, 1'b0, 4'h0};
        vt[9]  = '{1'b1, 4'h5, 2'd1, 1'b1, 1'b0, 4'h0};
        vt[10] = '{1'b1, 4'hA, 2'd0, 1'b0, 1'b0, 4'h0};
        vt[11] = '{1'b1, 4'h5, 2'd1, 1'b1, 1'b0, 4'h0};
        vt[12] = '{1'b0, 4'h2, 2'd1, 1'b1, 1'b0, 4'h0};
        vt[13] = '{1'b1, 4'h5, 2'd2, 1'b1, 1'b0, 4'h0};
        vt[14] = '{1'b1, 4'hA, 2'd0, 1'b0, 1'b0, 4'h0};
        vt[15] = '{1'b1, 4'h2, 2'd0, 1'b0, 1'b0, 4'h0};

        // reset state
        tick(); tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_core_rst_n", 32'(core_rst_n), 0);
        chk("rst_high", 32'(high_score), 0);
        chk("rst_step", 32'(step_en), 0);
        chk("rst_blink", 32'(blink), 0);

        // start at cycle 5; first step at 25, second at 45, first second at 55
        rst = 1'b0;
        cyc = 0;
        while (cyc < 5) tick();
        press(4'h5);
        chk("start_state", 32'(state), 1);
        chk("start_core_rst_n", 32'(core_rst_n), 1);
        while (cyc < 60) begin
            if (step_en) step_q.push_back(cyc);
            if (sec_en) sec_q.push_back(cyc);
            tick();
        end
        chk("first_step", (step_q.size() > 0) ? step_q[0] : -1, 25);
        chk("second_step", (step_q.size() > 1) ? step_q[1] : -1, 45);
        chk("first_sec", (sec_q.size() > 0) ? sec_q[0] : -1, 55);
        press(4'hA);
        chk("abort_state", 32'(state), 0);
        chk("abort_core_rst_n", 32'(core_rst_n), 0);

        // key decode table
        for (int i = 0; i < 16; i++) begin
            key_pressed = vt[i].kp;
            key_val = vt[i].kv;
            tick();
            key_pressed = 1'b0;
            key_val = 4'h0;
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(vt[i].e_state));
            chk($sformatf("vec%0d_rstn", i), 32'(core_rst_n), 32'(vt[i].e_rstn));
            chk($sformatf("vec%0d_ckp", i), 32'(core_key_pressed), 32'(vt[i].e_ckp));
            chk($sformatf("vec%0d_ckv", i), 32'(core_key_val), 32'(vt[i].e_ckv));
            chk($sformatf("vec%0d_step", i), 32'(step_en | sec_en), 0);
        end

        // speed-up schedule
        core_score = 7'd7;
        press(4'h5);
        wait_step(t0); wait_step(t1); wait_step(t2);
        chk("gap_score7", t2 - t1, 16);
        core_score = 7'd12;
        wait_step(t0); wait_step(t1); wait_step(t2);
        chk("gap_score12", t2 - t1, 12);
        core_score = 7'd99;
        wait_step(t0); wait_step(t1); wait_step(t2);
        chk("gap_score99", t2 - t1, 8);
        press(4'h8);
        chk("dir_ckp", 32'(core_key_pressed), 1);
        chk("dir_ckv", 32'(core_key_val), 8);
        tick();
        chk("dir_ckp_once", 32'(core_key_pressed), 0);

        // pause at step count 10, resume later
        core_score = 7'd0;
        wait_step(t0); wait_step(s);
        for (int i = 0; i < 11; i++) tick();
        m = cyc;
        press(4'h5);
        chk("pause_state", 32'(state), 2);
        ps = cyc;
        bad = 0; bbad = 0;
        for (int i = 0; i < 40; i++) begin
            if (step_en || sec_en || core_key_pressed) bad++;
            if (blink !== 1'(((cyc - ps) / 10) % 2)) bbad++;
            key_pressed = (i == 5);
            key_val = (i == 5) ? 4'h6 : 4'h0;
            tick();
        end
        key_pressed = 1'b0;
        key_val = 4'h0;
        chk("pause_quiet", bad, 0);
        chk("pause_blink", bbad, 0);
        r = cyc;
        first = -1;
        key_pressed = 1'b1;
        key_val = 4'h5;
        for (int i = 1; i <= 15; i++) begin
            tick();
            key_pressed = 1'b0;
            key_val = 4'h0;
            if (i == 1) begin
                chk("resume_state", 32'(state), 1);
                chk("resume_blink", 32'(blink), 0);
            end
            if (step_en && first < 0) first = cyc;
        end
        chk("resume_step", first - r, 10);

        // game over wins over KEY_SP in the same cycle
        core_score = 7'd9;
        core_game_over = 1'b1;
        g = cyc;
        press(4'h5);
        chk("over_state", 32'(state), 3);
        chk("over_high", 32'(high_score), 9);
        chk("over_ckp", 32'(core_key_pressed), 0);
        chk("over_core_rst_n", 32'(core_rst_n), 1);
        bad = 0;
        while (cyc < g + 20) begin
            if (step_en || sec_en) bad++;
            if (cyc == g + 10) chk("over_blink0", 32'(blink), 0);
            if (cyc == g + 11) chk("over_blink1", 32'(blink), 1);
            tick();
        end
        chk("over_no_pulses", bad, 0);
        press(4'h5);
        chk("over_hold_ignore", 32'(state), 3);
        while (cyc < g + 31) tick();
        press(4'h5);
        chk("over_exit_state", 32'(state), 0);
        chk("over_exit_rstn", 32'(core_rst_n), 0);
        core_game_over = 1'b0;
        core_score = 7'd0;

        // lower second score keeps high score
        press(4'h5);
        chk("game2_state", 32'(state), 1);
        tick(); tick(); tick();
        core_score = 7'd4;
        core_game_over = 1'b1;
        tick();
        chk("game2_over", 32'(state), 3);
        chk("game2_high", 32'(high_score), 9);
        for (int i = 0; i < 31; i++) tick();
        press(4'h5);
        chk("game2_idle", 32'(state), 0);
        core_game_over = 1'b0;
        core_score = 7'd0;

        // abort does not record the score
        press(4'h5);
        core_score = 7'd15;
        tick(); tick();
        press(4'hA);
        chk("game3_state", 32'(state), 0);
        chk("game3_high", 32'(high_score), 9);
        core_score = 7'd0;

        // asynchronous reset in the middle of a pause
        press(4'h5);
        tick(); tick();
        press(4'h5);
        chk("game4_pause", 32'(state), 2);
        for (int i = 0; i < 12; i++) tick();
        chk("game4_blink", 32'(blink), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_state", 32'(state), 0);
        chk("arst_rstn", 32'(core_rst_n), 0);
        chk("arst_high", 32'(high_score), 0);
        chk("arst_blink", 32'(blink), 0);
        chk("arst_pulses", 32'({core_key_pressed, core_key_val, step_en, sec_en}), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_state", 32'(state), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
